mem_port_arbiter: RTL and testbench

Sequencer and arbiter for the single memory port of the multicycle MIPS datapath. The instruction-fetch path (IR load) and the data path (MDR load/store) each request the port. The block grants one requester at a time, drives the memory MOV/RW strobes, waits for the memory's MOC completion, and returns read data with a one-cycle acknowledge. It sits between the DataPath/ControlUnit and the RAM model, so the ControlUnit no longer sequences MOV/MOC directly.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_watchdog.sv | 30 +++
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Access timeout counter. Cleared when a grant is issued, counts while the
// arbiter sits in ACCESS, and flags expiry on the TIMEOUT-th ACCESS cycle.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  // Cycle counter; saturates at the limit so expiry stays asserted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single memory port shared by instruction fetch
// and data load/store. Data has fixed priority over fetch.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT
// cycles without MOC (ack + err pulse). Undefined: ACCESS waits forever.
//
// Handshake: a requester raises req with stable addr/wdata and holds them
// until its ack pulse; ack is a one-cycle registered pulse with rdata valid
// in that cycle. On the memory side mem_mov stays high until mem_moc is
// sampled high, and no new grant is issued until mem_moc is seen low again.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_mov,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_moc,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          grant_d
);

  arb_state_t state, state_next;
  logic grant_load;
  logic grant_sel;
  logic done;
  logic timed_out;
  logic expired;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (grant_load),
    .en      (state == ACCESS),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_next = state;
    grant_load = 1'b0;
    grant_sel  = GRANT_IF;
    done       = 1'b0;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (d_req) begin
          grant_load = 1'b1;
          grant_sel  = GRANT_D;
          state_next = ACCESS;
        end else if (if_req) begin
          grant_load = 1'b1;
          grant_sel  = GRANT_IF;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        // A MOC in the limit cycle still counts as a normal completion.
        if (mem_moc) begin
          done       = 1'b1;
          state_next = RELEASE;
        end else if (expired) begin
          timed_out  = 1'b1;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!mem_moc) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Access latches, read data capture and ack pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_rw    <= RW_READ;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant_d   <= GRANT_IF;
      rdata     <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
    end else begin
      if_ack <= (done || timed_out) && (grant_d == GRANT_IF);
      d_ack  <= (done || timed_out) && (grant_d == GRANT_D);
      if (grant_load) begin
        grant_d <= grant_sel;
        if (grant_sel == GRANT_D) begin
          mem_addr  <= d_addr;
          mem_rw    <= d_rw;
          mem_wdata <= d_wdata;
        end else begin
          mem_addr  <= if_addr;
          mem_rw    <= RW_READ;
        end
      end
      if (done && (mem_rw == RW_READ)) begin
        rdata <= mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Error pulse accompanies the ack of an aborted access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= 1'b0;
    end else begin
      err <= timed_out;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign mem_mov = (state == ACCESS);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Honours MEM_ARB_TIMEOUT_EN for the
// timeout scenario.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic          d_req;
  logic          d_rw;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] rdata;
  logic          err;
  logic          mem_mov;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_moc;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          grant_d;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_rw      (d_rw),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .rdata     (rdata),
    .err       (err),
    .mem_mov   (mem_mov),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_moc   (mem_moc),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant_d   (grant_d)
  );

  // Clock.
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL global_timeout got=stalled exp=finished");
    $fatal(1, "bench stalled");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_rw = 1'b1;
    d_addr = '0; d_wdata = '0; mem_moc = 1'b0; mem_rdata = '0;
    tick(); tick();
    // Reset values
    check("rst_mov", mem_mov, 0);
    check("rst_rw", mem_rw, 1);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_if_ack", if_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_d", grant_d, 0);
    reset = 1'b1;
    tick();

    // Fetch only, MOC after 2 cycles
    if_req = 1'b1; if_addr = 32'h0000_0010;
    tick();
    check("f_mov", mem_mov, 1);
    check("f_rw", mem_rw, 1);
    check("f_addr", mem_addr, 32'h10);
    check("f_busy", busy, 1);
    check("f_grant", grant_d, 0);
    tick();
    check("f_no_early_ack", if_ack, 0);
    check("f_mov_hold", mem_mov, 1);
    mem_moc = 1'b1; mem_rdata = 32'h8C22_0004;
    tick();
    check("f_if_ack", if_ack, 1);
    check("f_rdata", rdata, 32'h8C22_0004);
    check("f_mov_drop", mem_mov, 0);
    check("f_d_ack", d_ack, 0);
    check("f_err", err, 0);
    if_req = 1'b0; mem_moc = 1'b0; mem_rdata = '0;
    tick();
    check("f_ack_pulse", if_ack, 0);
    check("f_idle", busy, 0);

    // Simultaneous requests: data write wins
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("s_grant_d", grant_d, 1);
    check("s_rw", mem_rw, 0);
    check("s_addr", mem_addr, 32'h40);
    check("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    mem_moc = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    check("s_d_ack", d_ack, 1);
    check("s_if_ack", if_ack, 0);
    check("s_rdata_kept", rdata, 32'h8C22_0004);
    d_req = 1'b0; mem_moc = 1'b0;
    tick();
    check("s_d_ack_pulse", d_ack, 0);
    check("s_idle", busy, 0);
    tick();
    check("s_f_mov", mem_mov, 1);
    check("s_f_grant", grant_d, 0);
    check("s_f_addr", mem_addr, 32'h20);
    check("s_f_rw", mem_rw, 1);
    mem_moc = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    check("s_f_ack", if_ack, 1);
    check("s_f_rdata", rdata, 32'h1234_5678);

    // Slow MOC release with a data read pending
    if_req = 1'b0;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h80;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r_mov_low", mem_mov, 0);
      check("r_busy", busy, 1);
      check("r_grant_held", grant_d, 0);
    end
    mem_moc = 1'b0;
    tick();
    check("r_idle", busy, 0);
    check("r_idle_mov", mem_mov, 0);
    tick();
    check("r_new_mov", mem_mov, 1);
    check("r_new_grant", grant_d, 1);
    check("r_new_addr", mem_addr, 32'h80);

    // Reset during ACCESS
    reset = 1'b0;
    tick();
    check("x_mov", mem_mov, 0);
    check("x_busy", busy, 0);
    check("x_d_ack", d_ack, 0);
    check("x_addr", mem_addr, 0);
    check("x_rdata", rdata, 0);
    reset = 1'b1; d_req = 1'b0; mem_moc = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    check("x_late_ack", d_ack, 0);
    check("x_late_busy", busy, 0);
    check("x_late_rdata", rdata, 0);
    mem_moc = 1'b0; mem_rdata = '0;
    tick();

    // Normal data read to seed rdata
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h44;
    tick();
    mem_moc = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    check("t_seed_ack", d_ack, 1);
    check("t_seed_rdata", rdata, 32'hCAFE_F00D);
    d_req = 1'b0; mem_moc = 1'b0; mem_rdata = '0;
    tick();
    check("t_seed_idle", busy, 0);

    // Data read with MOC never asserted
    d_req = 1'b1; d_rw = 1'b1; d_addr = 32'h48;
    tick();
    check("t_mov", mem_mov, 1);
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t_no_early_ack", d_ack, 0);
      check("t_no_early_err", err, 0);
    end
    tick();
    check("t_ack", d_ack, 1);
    check("t_err", err, 1);
    check("t_rdata_kept", rdata, 32'hCAFE_F00D);
    check("t_mov_drop", mem_mov, 0);
    d_req = 1'b0;
    tick();
    check("t_err_pulse", err, 0);
    check("t_idle", busy, 0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    check("t_still_busy", busy, 1);
    check("t_still_mov", mem_mov, 1);
    check("t_no_ack", d_ack, 0);
    check("t_no_err", err, 0);
    check("t_rdata_kept", rdata, 32'hCAFE_F00D);
    reset = 1'b0; d_req = 1'b0;
    tick();
    check("t_recover", busy, 0);
    reset = 1'b1;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
